// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared encodings for the interval timer controller.
//   timer_state_e : control FSM states (IDLE, LOAD, RUN)
//   MODE_*        : expiry behaviour selected by the latched mode bit
// -----------------------------------------------------------------------------
package timer_pkg;

    // Control FSM states. IDLE is all-zeros so the reset state is the
    // encoding's natural zero.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } timer_state_e;

    // Expiry behaviour: one-shot returns to IDLE, periodic reloads and runs on.
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage : timer_pkg

// File: rtl/counter_preset_sr.sv
// -----------------------------------------------------------------------------
// counter_preset_sr
// WIDTH-bit presettable up-counter with synchronous active-high reset.
// Load has priority over count-up.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous reset, active-high (count -> 0)
//   load    in   load count with preset this cycle
//   up      in   increment count this cycle (ignored while load is high)
//   preset  in   WIDTH-bit load value
//   count   out  WIDTH-bit counter register
//   carry   out  count is all ones: the next increment carries out and wraps
// -----------------------------------------------------------------------------
module counter_preset_sr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Counter register: reset, then load, then count-up, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= preset;
        end else if (up) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    // Terminal count is decoded from the register only, so it never depends
    // on load/up and cannot form a loop with the controller's decode.
    assign carry = &count_r;

endmodule : counter_preset_sr

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Programmable interval timer controller. Latches mode/period/prescale on an
// accepted start, presets an up-counter with -period and counts it up once per
// prescaled enable; expiry happens on the enable that finds the counter all
// ones. One-shot returns to IDLE, periodic reloads the preset and keeps going.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   start      in   start / retrigger command (level, sampled every cycle)
//   stop       in   abort command, wins over start
//   hold       in   freeze prescaler and counter while running
//   mode       in   0 one-shot, 1 periodic (latched at start)
//   period     in   enables to expiry, 1..2^WIDTH-1 (latched at start)
//   prescale   in   enable every prescale+1 clocks (latched at start)
//   busy       out  high in LOAD and RUN
//   tick       out  one-cycle expiry pulse
//   err        out  one-cycle pulse when a start with period 0 is rejected
//   remaining  out  enables left to expiry (two's-complement of the counter)
// -----------------------------------------------------------------------------
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      period,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  busy,
    output logic                  tick,
    output logic                  err,
    output logic [WIDTH-1:0]      remaining
);

    localparam logic [WIDTH-1:0]      CNT_ZERO   = {WIDTH{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    timer_state_e          state_r;
    logic                  mode_r;
    logic [WIDTH-1:0]      preset_r;
    logic [PRESCALE_W-1:0] prescale_r;
    logic [PRESCALE_W-1:0] presc_r;
    logic                  busy_r;
    logic                  tick_r;
    logic                  err_r;

    logic                  en_s;
    logic                  last_s;
    logic                  cnt_load_s;
    logic                  cnt_up_s;
    logic [WIDTH-1:0]      cnt_count_s;
    logic                  cnt_carry_s;

    // Enable and expiry decode; only meaningful while running
    always_comb begin
        en_s   = 1'b0;
        last_s = 1'b0;
        if (state_r == RUN) begin
            en_s   = (presc_r == prescale_r) && !hold;
            last_s = en_s && cnt_carry_s;
        end else begin
            en_s   = 1'b0;
            last_s = 1'b0;
        end
    end

    // Counter control: the datapath only acts on cycles with no stop/start,
    // so an abort or retrigger leaves the counter value untouched.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_up_s   = 1'b0;
        if (rst || stop || start) begin
            cnt_load_s = 1'b0;
            cnt_up_s   = 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    cnt_load_s = 1'b1;
                end
                RUN: begin
                    // Periodic expiry reloads instead of wrapping through zero.
                    if (last_s && (mode_r == MODE_PERIODIC)) begin
                        cnt_load_s = 1'b1;
                    end else if (en_s) begin
                        cnt_up_s = 1'b1;
                    end else begin
                        cnt_up_s = 1'b0;
                    end
                end
                default: begin
                    cnt_load_s = 1'b0;
                    cnt_up_s   = 1'b0;
                end
            endcase
        end
    end

    // Control FSM, config latches, prescaler and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            mode_r     <= MODE_ONESHOT;
            preset_r   <= CNT_ZERO;
            prescale_r <= PRESC_ZERO;
            presc_r    <= PRESC_ZERO;
            busy_r     <= 1'b0;
            tick_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            err_r  <= 1'b0;

            // Prescaler starts from zero on entry to RUN, freezes under hold
            // and wraps on every enable (including periodic expiry).
            if (state_r == LOAD) begin
                presc_r <= PRESC_ZERO;
            end else if ((state_r == RUN) && !hold) begin
                presc_r <= en_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
            end else begin
                presc_r <= presc_r;
            end

            if (stop) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else if (start) begin
                if (period != CNT_ZERO) begin
                    mode_r     <= mode;
                    preset_r   <= CNT_ZERO - period;
                    prescale_r <= prescale;
                    state_r    <= LOAD;
                    busy_r     <= 1'b1;
                end else begin
                    // A rejected start also abandons any run in progress, so
                    // err and tick can never coincide.
                    err_r   <= 1'b1;
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    LOAD: begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end
                    RUN: begin
                        if (last_s) begin
                            tick_r <= 1'b1;
                            if (mode_r == MODE_ONESHOT) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= RUN;
                                busy_r  <= 1'b1;
                            end
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    counter_preset_sr #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load_s),
        .up     (cnt_up_s),
        .preset (preset_r),
        .count  (cnt_count_s),
        .carry  (cnt_carry_s)
    );

    assign busy      = busy_r;
    assign tick      = tick_r;
    assign err       = err_r;
    // Counter holds -remaining, so negating the register gives the count left.
    assign remaining = CNT_ZERO - cnt_count_s;

endmodule : timer_ctrl

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
// Directed scenarios followed by random commands, each cycle compared against
// a reference model that tracks "enables left" and a prescale phase directly.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       hold;
    logic       mode;
    logic [7:0] period;
    logic [3:0] prescale;
    logic       busy;
    logic       tick;
    logic       err;
    logic [7:0] remaining;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_st    = 0;   // 0 idle, 1 load, 2 run
    int   m_left  = 0;   // enables left to expiry == remaining
    int   m_phase = 0;   // clocks since last enable
    int   m_p     = 0;
    int   m_s     = 0;
    bit   m_mode  = 1'b0;
    logic exp_busy = 1'b0;
    logic exp_tick = 1'b0;
    logic exp_err  = 1'b0;
    logic [7:0] exp_rem = 8'd0;

    timer_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .mode      (mode),
        .period    (period),
        .prescale  (prescale),
        .busy      (busy),
        .tick      (tick),
        .err       (err),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the model by one clock using the inputs sampled at that edge.
    task automatic model_step();
        bit t = 1'b0;
        bit e = 1'b0;
        if (rst) begin
            m_st = 0; m_left = 0; m_phase = 0;
        end else if (stop) begin
            m_st = 0;
        end else if (start) begin
            if (period != 8'd0) begin
                m_p = int'(period); m_s = int'(prescale); m_mode = mode; m_st = 1;
            end else begin
                e = 1'b1; m_st = 0;
            end
        end else if (m_st == 1) begin
            m_left = m_p; m_phase = 0; m_st = 2;
        end else if (m_st == 2 && !hold) begin
            if (m_phase == m_s) begin
                m_phase = 0;
                if (m_left == 1) begin
                    t = 1'b1;
                    if (m_mode) m_left = m_p;
                    else begin m_left = 0; m_st = 0; end
                end else begin
                    m_left = m_left - 1;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
        exp_tick = t;
        exp_err  = e;
        exp_busy = (m_st != 0);
        exp_rem  = 8'(m_left);
    endtask

    // One clock: model at the edge, compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_busy", busy, exp_busy);
        chk("m_tick", tick, exp_tick);
        chk("m_err", err, exp_err);
        chk("m_rem", remaining, exp_rem);
    endtask

    // One-shot P=3, S=0 started in cycle 0.
    task automatic scen_oneshot3();
        int eb[5] = '{1, 1, 1, 1, 0};
        int et[5] = '{0, 0, 0, 0, 1};
        int er[5] = '{0, 3, 2, 1, 0};
        start = 1'b1; period = 8'd3; prescale = 4'd0; mode = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            start = 1'b0;
            chk("s1_busy", busy, eb[c-1]);
            chk("s1_tick", tick, et[c-1]);
            chk("s1_rem", remaining, er[c-1]);
        end
        cyc();
        chk("s1_idle_tick", tick, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
        period = 8'd0; prescale = 4'd0;
        cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_rem", remaining, 8'd0);
        rst = 1'b0;
        cyc();

        // Scenario 1: one-shot basic.
        scen_oneshot3();

        // Scenario 2: periodic P=2 S=2, stop in cycle 19.
        for (int c = 1; c <= 20; c++) begin
            start = (c == 1); stop = (c == 20);
            period = 8'd2; prescale = 4'd2; mode = 1'b1;
            cyc();
            chk("s2_tick", tick, (c == 8 || c == 14));
        end
        chk("s2_busy_after_stop", busy, 1'b0);
        stop = 1'b0;
        cyc();

        // Scenario 3: rejected start, then longest period/prescale.
        start = 1'b1; period = 8'd0; prescale = 4'd0; mode = 1'b0;
        cyc();
        chk("s3_err", err, 1'b1);
        chk("s3_busy", busy, 1'b0);
        start = 1'b0;
        cyc();
        chk("s3_err_once", err, 1'b0);
        start = 1'b1; period = 8'd255; prescale = 4'd15; mode = 1'b0;
        for (int c = 1; c <= 4083; c++) begin
            cyc();
            start = 1'b0;
            if (c == 4081 || c == 4082 || c == 4083) chk("s3_tick", tick, (c == 4082));
        end

        // Scenario 4: hold during cycles 3-5 defers expiry to cycle 9.
        start = 1'b1; period = 8'd4; prescale = 4'd0; mode = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            start = 1'b0;
            hold = (c >= 3 && c <= 5);
            chk("s4_tick", tick, (c == 9));
            if (c >= 4 && c <= 6) chk("s4_rem_hold", remaining, 8'd3);
        end
        hold = 1'b0;

        // Scenario 5: retrigger on the expiry cycle, then start+stop together.
        start = 1'b1; period = 8'd2; prescale = 4'd0; mode = 1'b0;
        cyc(); start = 1'b0;
        cyc(); cyc();
        start = 1'b1; period = 8'd5;    // cycle 3 is the last enable
        cyc();
        chk("s5_no_tick", tick, 1'b0);
        chk("s5_busy_load", busy, 1'b1);
        start = 1'b0;
        cyc();
        chk("s5_rem", remaining, 8'd5);
        start = 1'b1; stop = 1'b1;
        cyc();
        chk("s5_stop_busy", busy, 1'b0);
        start = 1'b0; stop = 1'b0;
        cyc();

        // Scenario 6: reset mid-run, then the basic one-shot again.
        start = 1'b1; period = 8'd10; prescale = 4'd1; mode = 1'b1;
        cyc(); start = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        rst = 1'b1;
        cyc();
        chk("s6_busy", busy, 1'b0);
        chk("s6_rem", remaining, 8'd0);
        chk("s6_tick", tick, 1'b0);
        chk("s6_err", err, 1'b0);
        rst = 1'b0;
        scen_oneshot3();

        // Random commands against the model.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            mode     = 1'($urandom_range(0, 1));
            period   = 8'($urandom_range(0, 6));
            prescale = 4'($urandom_range(0, 3));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_timer_ctrl
